// File: rtl/data_mem_responder.sv
// data_mem_responder
// Fixed-latency data-memory slave. It accepts one request at a time and
// owns a word-organised 16-bit storage array. A request accepted in IDLE
// or RESP waits LATENCY cycles and is then answered with a one-cycle
// data_valid pulse. err qualifies that pulse for misaligned requests.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic                  mis_q, mis_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [15:0]           data_out_q;
    logic                  access;

    logic [15:0]           mem [2**ADDR_WIDTH];

    // The upper byte-address bits alias and are intentionally ignored
    if (ADDR_WIDTH < 15) begin : g_alias
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr[15:ADDR_WIDTH+1];
    end

    // Next state, request latching and access strobe
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        mis_d   = mis_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        access  = 1'b0;
        unique case (state_q)
            IDLE, RESP: begin
                if (enable) begin
                    state_d = WAIT;
                    cnt_d   = CNT_LOAD;
                    wr_d    = wr;
                    mis_d   = addr[0];
                    idx_d   = addr[ADDR_WIDTH:1];
                    wdata_d = data_in;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, latched request and registered read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            mis_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            data_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            mis_q   <= mis_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            if (access && !wr_q && !mis_q) begin
                data_out_q <= mem[idx_q];
            end
        end
    end

    // Array write; contents are not reset and an aborted write never commits
    always_ff @(posedge clk) begin
        if (!rst && access && wr_q && !mis_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign data_out   = data_out_q;
    assign busy       = (state_q == WAIT);
    assign data_valid = (state_q == RESP);
    assign err        = (state_q == RESP) && mis_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one LATENCY=4 instance for the main
// scenarios and one LATENCY=1 instance for the short-latency build.
module tb_data_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        enable = 1'b0, wr = 1'b0;
    logic [15:0] addr = '0, data_in = '0;
    logic [15:0] data_out;
    logic        data_valid, busy, err;

    logic        enable1 = 1'b0, wr1 = 1'b0;
    logic [15:0] addr1 = '0, data_in1 = '0;
    logic [15:0] data_out1;
    logic        data_valid1, busy1, err1;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
        .busy(busy), .err(err)
    );

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable1), .wr(wr1), .addr(addr1),
        .data_in(data_in1), .data_out(data_out1), .data_valid(data_valid1),
        .busy(busy1), .err(err1)
    );

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, act, exp, $time);
        end
    endtask

    // One request on the LATENCY=4 instance. b2b drives it in the current
    // (RESP) cycle; pulse injects a write of 0x1111 to 0x0022 while busy.
    task automatic req(input bit w, input logic [15:0] a, input logic [15:0] d,
                       input bit b2b, input bit pulse, input logic exp_err,
                       input logic [15:0] exp_do, input string tag);
        if (!b2b) @(negedge clk);
        enable = 1'b1; wr = w; addr = a; data_in = d;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            if (i == 0) enable = 1'b0;
            if (pulse && i == 1) begin
                enable = 1'b1; wr = 1'b1; addr = 16'h0022; data_in = 16'h1111;
            end
            if (pulse && i == 2) enable = 1'b0;
            check_eq({tag, "_busy"}, 16'(busy), 16'd1);
            check_eq({tag, "_dv_wait"}, 16'(data_valid), 16'd0);
        end
        @(negedge clk);
        check_eq({tag, "_dv"}, 16'(data_valid), 16'd1);
        check_eq({tag, "_busy_resp"}, 16'(busy), 16'd0);
        check_eq({tag, "_err"}, 16'(err), 16'(exp_err));
        check_eq({tag, "_data"}, data_out, exp_do);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_data", data_out, 16'h0000);
        check_eq("rst_dv", 16'(data_valid), 16'd0);
        check_eq("rst_busy", 16'(busy), 16'd0);
        check_eq("rst_err", 16'(err), 16'd0);
        rst = 1'b0;

        req(1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0000, "wr_beef");
        @(negedge clk);
        check_eq("dv_drop", 16'(data_valid), 16'd0);
        req(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hBEEF, "rd_beef");

        req(1'b1, 16'h0022, 16'h0BAD, 1'b0, 1'b0, 1'b0, 16'hBEEF, "wr_22");
        req(1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0, 1'b0, 16'hBEEF, "wr_20");
        req(1'b0, 16'h0020, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1234, "b2b_rd_20");
        req(1'b0, 16'h0022, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0BAD, "rd_22");

        req(1'b1, 16'h0011, 16'h5555, 1'b0, 1'b0, 1'b1, 16'h0BAD, "mis_wr");
        @(negedge clk);
        check_eq("mis_err_drop", 16'(err), 16'd0);
        req(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hBEEF, "rd_after_mis");

        req(1'b1, 16'hFFFE, 16'hA5A5, 1'b0, 1'b0, 1'b0, 16'hBEEF, "wr_alias");
        req(1'b0, 16'h07FE, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hA5A5, "rd_alias");

        req(1'b1, 16'h0030, 16'h3333, 1'b0, 1'b0, 1'b0, 16'hA5A5, "wr_3333");
        @(negedge clk);
        enable = 1'b1; wr = 1'b1; addr = 16'h0030; data_in = 16'h2222;
        @(negedge clk);
        check_eq("abort_busy_pre", 16'(busy), 16'd1);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort_busy", 16'(busy), 16'd0);
        check_eq("abort_dv", 16'(data_valid), 16'd0);
        check_eq("abort_data", data_out, 16'h0000);
        check_eq("abort_err", 16'(err), 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req(1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h3333, "rd_after_abort");
        @(negedge clk);
        check_eq("idle_dv", 16'(data_valid), 16'd0);
        check_eq("idle_busy", 16'(busy), 16'd0);

        // LATENCY=1: write, then reads accepted at every RESP edge
        @(negedge clk);
        enable1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0004; data_in1 = 16'hCAFE;
        @(negedge clk);
        check_eq("l1_wr_busy", 16'(busy1), 16'd1);
        check_eq("l1_wr_dv0", 16'(data_valid1), 16'd0);
        wr1 = 1'b0;
        @(negedge clk);
        check_eq("l1_wr_dv", 16'(data_valid1), 16'd1);
        check_eq("l1_wr_busy0", 16'(busy1), 16'd0);
        check_eq("l1_wr_data", data_out1, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("l1_rd_busy", 16'(busy1), 16'd1);
            check_eq("l1_rd_dv0", 16'(data_valid1), 16'd0);
            @(negedge clk);
            check_eq("l1_rd_dv", 16'(data_valid1), 16'd1);
            check_eq("l1_rd_err", 16'(err1), 16'd0);
            check_eq("l1_rd_data", data_out1, 16'hCAFE);
        end
        enable1 = 1'b0;
        @(negedge clk);
        check_eq("l1_idle_busy", 16'(busy1), 16'd0);
        check_eq("l1_idle_dv", 16'(data_valid1), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
